// File: rtl/soft_trig_burst_sequencer.sv
// Software-armed trigger burst sequencer for the FOFB event-receiver path.
// After an arm and a synchronised soft-event edge, each accepted evg_trig
// produces one trig_out pulse cfg_delay cycles later. The burst ends after the
// latched shot count, on WAIT_TRIG timeout, or on abort.
//
// Handshake note: arm, abort, evg_trig and the internal soft edge are
// single-cycle strobes with no ready/back-pressure. A strobe counts only in a
// cycle where clk_enable=1 and the FSM is in a state that consumes it.
// Otherwise it is dropped, never queued.
module soft_trig_burst_sequencer #(
  parameter int DLY_W = 24,
  parameter int CNT_W = 16,
  parameter int TO_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             arm,
  input  logic             abort,
  input  logic             evg_soft_event,
  input  logic             evg_trig,
  input  logic [63:0]      evr_TS,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_burst,
  input  logic [TO_W-1:0]  cfg_timeout,
  output logic             trig_out,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] shot_count,
  output logic [31:0]      trig_count,
  output logic [63:0]      ts_latched
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMED     = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_DELAY     = 3'd3,
    S_FIRE      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             sync1, sync2, sync3, soft_edge;
  logic [DLY_W-1:0] dly_lat, dly_cnt;
  logic [CNT_W-1:0] burst_lat;
  logic [TO_W-1:0]  to_lat, to_cnt;
  logic [CNT_W-1:0] shot_next;
  logic             last_shot;
  logic             accept_arm, accept_trig, firing, to_expire, enter_wait;

  assign state     = state_q;
  assign busy      = (state_q != S_IDLE);
  assign shot_next = shot_count + 1'b1;
  assign last_shot = (shot_next == burst_lat);

  // Qualified events: every one requires clk_enable, and abort overrides all
  // of them except the FIRE pulse itself.
  assign accept_arm  = clk_enable && !abort && (state_q == S_IDLE) && arm;
  assign accept_trig = clk_enable && !abort && (state_q == S_WAIT_TRIG) && evg_trig;
  assign firing      = clk_enable && (state_q == S_FIRE);
  assign to_expire   = clk_enable && !abort && (state_q == S_WAIT_TRIG) && !evg_trig &&
                       (to_lat != '0) && (to_cnt == '0);
  assign enter_wait  = clk_enable && (state_d == S_WAIT_TRIG) && (state_q != S_WAIT_TRIG);

  // Pulse outputs: trig_out only in FIRE, done only on the final shot of a
  // burst that was not aborted; both forced low while disabled.
  assign trig_out = firing;
  assign done     = firing && !abort && last_shot;

  // Soft-event synchroniser and rising-edge detect; free-running, ignores clk_enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      soft_edge <= 1'b0;
    end else begin
      sync1     <= evg_soft_event;
      sync2     <= sync1;
      sync3     <= sync2;
      soft_edge <= sync2 & ~sync3;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; holds when disabled, abort returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (clk_enable) begin
      if (abort) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE:      if (arm) state_d = S_ARMED;
          S_ARMED:     if (soft_edge) state_d = S_WAIT_TRIG;
          S_WAIT_TRIG: begin
            if (evg_trig)       state_d = (dly_lat == '0) ? S_FIRE : S_DELAY;
            else if (to_expire) state_d = S_IDLE;
          end
          S_DELAY:     if (dly_cnt == '0) state_d = S_FIRE;
          S_FIRE:      state_d = last_shot ? S_IDLE : S_WAIT_TRIG;
          default:     state_d = S_IDLE;
        endcase
      end
    end
  end

  // Config latches, delay/timeout counters, status counters and timestamp.
  always_ff @(posedge clk) begin
    if (reset) begin
      dly_lat     <= '0;
      burst_lat   <= '0;
      to_lat      <= '0;
      dly_cnt     <= '0;
      to_cnt      <= '0;
      shot_count  <= '0;
      trig_count  <= '0;
      ts_latched  <= '0;
      timeout_err <= 1'b0;
    end else if (clk_enable) begin
      if (accept_arm) begin
        dly_lat     <= cfg_delay;
        burst_lat   <= (cfg_burst == '0) ? CNT_W'(1) : cfg_burst;
        to_lat      <= cfg_timeout;
        shot_count  <= '0;
        timeout_err <= 1'b0;
      end
      if (firing) begin
        shot_count <= shot_next;
        trig_count <= trig_count + 32'd1;
      end
      if (accept_trig) begin
        ts_latched <= evr_TS;
        if (dly_lat != '0) dly_cnt <= dly_lat - 1'b1;
      end else if (state_q == S_DELAY && dly_cnt != '0) begin
        dly_cnt <= dly_cnt - 1'b1;
      end
      // The timeout window is exactly to_lat cycles spent in WAIT_TRIG.
      if (enter_wait) begin
        to_cnt <= to_lat - 1'b1;
      end else if (state_q == S_WAIT_TRIG && to_cnt != '0) begin
        to_cnt <= to_cnt - 1'b1;
      end
      if (to_expire) timeout_err <= 1'b1;
    end
  end

endmodule
